note_spawner: RTL and testbench

- Consumes the serial pseudo-random bit stream from the LFSR bit generator, one bit per clk.
- Packs the bits into a lane pattern plus a probability roll, and on each beat tick decides whether to spawn a note.
- Offers each spawned note to the note-scroll/display logic over a valid/ready handshake.
- Sits between the random bit source and the falling-note display pipeline.

---
 rtl/note_spawner.sv | 103 ++++++++++
 tb/tb_note_spawner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/note_spawner.sv
// Packs the serial random stream into a lane mask plus roll and spawns notes on beats; output is held valid/ready.
// Optional NOTE_SPAWNER_STATS_EN adds saturating accepted-note and missed-beat counters.
module note_spawner #(
  parameter int LANES        = 4,
  parameter int DENSITY_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rand_bit,
  input  logic                    enable,
  input  logic                    beat_tick,
  input  logic [DENSITY_BITS-1:0] density,
  output logic                    note_valid,
  output logic [LANES-1:0]        note_lanes,
  input  logic                    note_ready,
`ifdef NOTE_SPAWNER_STATS_EN
  output logic [15:0]             note_count,
  output logic [15:0]             miss_count,
`endif
  output logic                    overrun
);

  localparam int W  = LANES + DENSITY_BITS;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] FULL = CW'(W);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] OFFER   = 2'd2;

  logic [1:0]              state;
  logic [W-1:0]            shreg;
  logic [CW-1:0]           bit_cnt;
  logic [LANES-1:0]        lanes_raw;
  logic [LANES-1:0]        lanes_fix;
  logic [DENSITY_BITS-1:0] roll;
  logic                    decide;

  assign lanes_raw = shreg[W-1:DENSITY_BITS];
  assign roll      = shreg[DENSITY_BITS-1:0];
  // An all-zero mask would be an invisible note, so lane 0 is forced.
  assign lanes_fix = (lanes_raw == '0) ? LANES'(1) : lanes_raw;
  assign decide    = (state == COLLECT) && enable && beat_tick && (bit_cnt == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      note_valid <= 1'b0;
      note_lanes <= '0;
      overrun    <= 1'b0;
    end else begin
      shreg   <= {shreg[W-2:0], rand_bit};
      overrun <= 1'b0;
      if (decide)
        bit_cnt <= '0;
      else if (bit_cnt != FULL)
        bit_cnt <= bit_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (enable)
            state <= COLLECT;
        end
        COLLECT: begin
          if (!enable)
            state <= IDLE;
          else if (decide && (roll < density)) begin
            note_lanes <= lanes_fix;
            note_valid <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (note_ready) begin
            note_valid <= 1'b0;
            note_lanes <= '0;
            state      <= enable ? COLLECT : IDLE;
          end else if (beat_tick) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOTE_SPAWNER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_count <= '0;
      miss_count <= '0;
    end else begin
      if ((state == OFFER) && note_ready && (note_count != 16'hFFFF))
        note_count <= note_count + 16'd1;
      if ((state == OFFER) && !note_ready && beat_tick && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_note_spawner.sv
// Directed bench for note_spawner with default parameters (LANES=4, DENSITY_BITS=2, 6 bits per decision).
module tb_note_spawner;

  logic       clk;
  logic       reset;
  logic       rand_bit;
  logic       enable;
  logic       beat_tick;
  logic [1:0] density;
  logic       note_valid;
  logic [3:0] note_lanes;
  logic       note_ready;
  logic       overrun;
`ifdef NOTE_SPAWNER_STATS_EN
  logic [15:0] note_count;
  logic [15:0] miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  note_spawner #(.LANES(4), .DENSITY_BITS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rand_bit   (rand_bit),
    .enable     (enable),
    .beat_tick  (beat_tick),
    .density    (density),
    .note_valid (note_valid),
    .note_lanes (note_lanes),
    .note_ready (note_ready),
`ifdef NOTE_SPAWNER_STATS_EN
    .note_count (note_count),
    .miss_count (miss_count),
`endif
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks happen at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [5:0] bits);
    for (int i = 5; i >= 0; i--) begin
      rand_bit = bits[i];
      tick();
    end
    rand_bit = 1'b0;
  endtask

  task automatic beat();
    beat_tick = 1'b1;
    tick();
    beat_tick = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    rand_bit   = 1'b0;
    enable     = 1'b1;
    beat_tick  = 1'b0;
    density    = 2'd3;
    note_ready = 1'b0;
    tick();
    tick();
    check("rst_valid",   32'(note_valid), 32'd0);
    check("rst_lanes",   32'(note_lanes), 32'd0);
    check("rst_overrun", 32'(overrun),    32'd0);
    reset = 1'b1;

    // Basic spawn: lanes 1011, roll 01 < 3
    feed(6'b101101);
    beat();
    check("t1_valid", 32'(note_valid), 32'd1);
    check("t1_lanes", 32'(note_lanes), 32'hB);
    note_ready = 1'b1;
    tick();
    note_ready = 1'b0;
    check("t1_accept_valid", 32'(note_valid), 32'd0);
    check("t1_accept_lanes", 32'(note_lanes), 32'd0);

    // Zero mask forced to lane 0 (roll 10 < 3)
    feed(6'b000010);
    beat();
    check("t2_valid", 32'(note_valid), 32'd1);
    check("t2_lanes", 32'(note_lanes), 32'h1);
    note_ready = 1'b1;
    tick();
    note_ready = 1'b0;
    check("t2_accept_valid", 32'(note_valid), 32'd0);

    // roll 3 not < 3
    feed(6'b111111);
    beat();
    check("t3_roll3_valid", 32'(note_valid), 32'd0);
    tick();
    check("t3_roll3_valid_later", 32'(note_valid), 32'd0);

    // density 0 never spawns, even with roll 0
    density = 2'd0;
    feed(6'b100000);
    beat();
    check("t3_dens0_valid", 32'(note_valid), 32'd0);
    density = 2'd3;

    // Overrun while note pending, then accept together with a beat
    feed(6'b101101);
    beat();
    check("t4_valid", 32'(note_valid), 32'd1);
    check("t4_lanes", 32'(note_lanes), 32'hB);
    check("t4_no_overrun_yet", 32'(overrun), 32'd0);
    feed(6'b000000);
    beat();
    check("t4_overrun_hi", 32'(overrun),    32'd1);
    check("t4_held_valid", 32'(note_valid), 32'd1);
    check("t4_held_lanes", 32'(note_lanes), 32'hB);
    tick();
    check("t4_overrun_lo", 32'(overrun),    32'd0);
    check("t4_still_lanes", 32'(note_lanes), 32'hB);
    note_ready = 1'b1;
    beat();
    note_ready = 1'b0;
    check("t4_accept_valid",   32'(note_valid), 32'd0);
    check("t4_accept_overrun", 32'(overrun),    32'd0);
    tick();
    check("t4_accept_overrun2", 32'(overrun), 32'd0);
`ifdef NOTE_SPAWNER_STATS_EN
    check("t4_note_count", 32'(note_count), 32'd3);
    check("t4_miss_count", 32'(miss_count), 32'd1);
`endif

    // Beat with too few bits since last decision is skipped
    feed(6'b111111);
    beat();
    check("t5_decide_nonote", 32'(note_valid), 32'd0);
    tick();
    tick();
    tick();
    beat();
    check("t5_short_valid",   32'(note_valid), 32'd0);
    check("t5_short_overrun", 32'(overrun),    32'd0);
    tick();
    check("t5_short_overrun2", 32'(overrun), 32'd0);
    feed(6'b101101);
    beat();
    check("t5_normal_valid", 32'(note_valid), 32'd1);
    check("t5_normal_lanes", 32'(note_lanes), 32'hB);

    // Async reset mid-cycle with a note pending and overrun high
    beat();
    check("t6_overrun_hi", 32'(overrun), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid",   32'(note_valid), 32'd0);
    check("t6_rst_lanes",   32'(note_lanes), 32'd0);
    check("t6_rst_overrun", 32'(overrun),    32'd0);
    tick();
    reset = 1'b1;
    // 5 bits only: shreg would hold a winning pattern, but the count is short
    rand_bit = 1'b1; tick();
    rand_bit = 1'b1; tick();
    rand_bit = 1'b0; tick();
    rand_bit = 1'b0; tick();
    rand_bit = 1'b0; tick();
    beat();
    check("t6_five_bits_valid", 32'(note_valid), 32'd0);
    feed(6'b011000);
    beat();
    check("t6_post_valid", 32'(note_valid), 32'd1);
    check("t6_post_lanes", 32'(note_lanes), 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
